// File: rtl/shared_wport_mem.sv
// Word-addressed memory whose single write port is shared by NCH slice writers
// through a valid/ready arbiter, with one registered read port and a stall counter.
module shared_wport_mem #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 4,
    parameter int SLICE_W        = 16,
    parameter int NCH            = 3,
    parameter int OFF_STEP       = 8,
    parameter int ARB_RR         = 0,
    parameter int RD_TRANSPARENT = 0,
    parameter int CNT_W          = 16,
    localparam int PTR_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          wr_valid,
    output logic [NCH-1:0]          wr_ready,
    input  logic [NCH*ADDR_W-1:0]   wr_addr,
    input  logic [NCH*SLICE_W-1:0]  wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [WORD_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [PTR_W-1:0]        rr_ptr
);

    localparam int DEPTH = 1 << ADDR_W;

    if ((NCH - 1) * OFF_STEP + SLICE_W > WORD_W) begin : g_bad_geometry
        $error("shared_wport_mem: highest channel slice does not fit in WORD_W");
    end

    // Handshake: a channel raises wr_valid and holds address/data stable until it
    // sees wr_ready; the write commits on the rising edge where both are high.
    // wr_ready is combinational from wr_valid and rr_ptr, one-hot or zero.

    logic [WORD_W-1:0] mem [DEPTH];
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [SLICE_W-1:0] sel_data;
    logic [WORD_W-1:0] merged;
    logic              waiting;

    function automatic int wrap_idx(input int base, input int k);
        int c;
        c = base + k;
        if (c >= NCH) c = c - NCH;
        return c;
    endfunction

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!rst) begin
            if (ARB_RR == 0) begin
                // Descending scan so the lowest valid index is the last one kept.
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (wr_valid[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PTR_W'(i);
                    end
                end
            end else begin
                for (int k = NCH - 1; k >= 0; k--) begin
                    if (wr_valid[wrap_idx(int'(rr_ptr), k)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PTR_W'(wrap_idx(int'(rr_ptr), k));
                    end
                end
            end
        end
    end

    assign wr_ready = gnt_any ? (NCH'(1) << gnt_idx) : '0;
    assign sel_addr = wr_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data = wr_data[gnt_idx*SLICE_W +: SLICE_W];
    assign waiting  = |(wr_valid & ~wr_ready);

    always_comb begin
        merged = mem[sel_addr];
        merged[gnt_idx*OFF_STEP +: SLICE_W] = sel_data;
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && gnt_any) begin
            mem[sel_addr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            if (RD_TRANSPARENT != 0 && gnt_any && rd_addr == sel_addr) begin
                rd_data <= merged;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            if (waiting && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shared_wport_mem.sv
// Bench for shared_wport_mem: two instances (fixed priority / opaque read / 16-bit
// counter and round-robin / transparent read / 3-bit counter) against a word-array model.
module tb_shared_wport_mem;

  logic        clk;
  logic        rst;
  logic [2:0]  wr_valid [2];
  logic [2:0]  wr_ready [2];
  logic [11:0] wr_addr  [2];
  logic [47:0] wr_data  [2];
  logic        rd_en    [2];
  logic [3:0]  rd_addr  [2];
  logic [31:0] rd_data  [2];
  logic        rd_valid [2];
  logic [1:0]  rr_ptr   [2];
  logic [15:0] stall_a;
  logic [2:0]  stall_b;

  shared_wport_mem #(.ARB_RR(0), .RD_TRANSPARENT(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
    .stall_cnt(stall_a), .rr_ptr(rr_ptr[0])
  );

  shared_wport_mem #(.ARB_RR(1), .RD_TRANSPARENT(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
    .stall_cnt(stall_b), .rr_ptr(rr_ptr[1])
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model and scoreboard state ----------------
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] m_mem [2][16];
  int          m_ptr [2];
  int          m_stall [2];

  bit   [2:0]  want [2];
  logic [3:0]  want_addr [2][3];
  logic [15:0] want_data [2][3];
  bit          rd_req [2];
  logic [3:0]  rd_at [2];
  bit          rst_req;

  bit          pend [2][3];
  logic [3:0]  p_addr [2][3];
  logic [15:0] p_data [2][3];
  bit          regs_known;
  bit          prev_rst;

  int n_cmp;
  int n_err;

  function automatic int stall_max(input int d);
    return (d == 0) ? 65535 : 7;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input int d, input int ch, input logic [3:0] a, input logic [15:0] dat);
    want[d][ch]      = 1'b1;
    want_addr[d][ch] = a;
    want_data[d][ch] = dat;
  endtask

  task automatic req_both(input int ch, input logic [3:0] a, input logic [15:0] dat);
    for (int d = 0; d < 2; d++) req(d, ch, a, dat);
  endtask

  task automatic rd_both(input logic [3:0] a);
    for (int d = 0; d < 2; d++) begin
      rd_req[d] = 1'b1;
      rd_at[d]  = a;
    end
  endtask

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++)
        r |= pend[d][i];
    return r;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, predict the grant and
  // advance the model to the state the coming rising edge should produce.
  task automatic step();
    int g;
    int npend;
    int c;
    logic [31:0] nw;
    logic [31:0] stall_act;
    @(negedge clk);
    if (regs_known) begin
      for (int d = 0; d < 2; d++) begin
        stall_act = (d == 0) ? {16'h0, stall_a} : {29'h0, stall_b};
        chk("stall_cnt", d, stall_act, m_stall[d]);
        chk("rr_ptr", d, {30'h0, rr_ptr[d]}, m_ptr[d]);
        if (prev_rst) begin
          chk("rd_data_after_rst", d, rd_data[d], 32'h0);
          chk("rd_valid_after_rst", d, {31'h0, rd_valid[d]}, 32'h0);
        end
      end
    end
    rst = rst_req;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[d][i] && want[d][i]) begin
          pend[d][i]   = 1'b1;
          p_addr[d][i] = want_addr[d][i];
          p_data[d][i] = want_data[d][i];
        end
        wr_valid[d][i]          = pend[d][i];
        wr_addr[d][i*4 +: 4]    = p_addr[d][i];
        wr_data[d][i*16 +: 16]  = p_data[d][i];
      end
      rd_en[d]   = rd_req[d];
      rd_addr[d] = rd_at[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      g = -1;
      if (!rst_req) begin
        for (int k = 0; k < 3; k++) begin
          c = (d == 0) ? k : (m_ptr[d] + k) % 3;
          if (g < 0 && pend[d][c]) g = c;
        end
      end
      chk("wr_ready", d, {29'h0, wr_ready[d]}, (g >= 0) ? (32'd1 << g) : 32'd0);
      if (rst_req) begin
        m_ptr[d]   = 0;
        m_stall[d] = 0;
      end else begin
        npend = 0;
        for (int i = 0; i < 3; i++) npend += int'(pend[d][i]);
        nw = 32'h0;
        if (g >= 0) begin
          nw = m_mem[d][p_addr[d][g]];
          nw[g*8 +: 16] = p_data[d][g];
        end
        if (rd_req[d]) begin
          if (d == 1 && g >= 0 && p_addr[d][g] == rd_at[d]) exp_q1.push_back(nw);
          else if (d == 1) exp_q1.push_back(m_mem[d][rd_at[d]]);
          else exp_q0.push_back(m_mem[d][rd_at[d]]);
        end
        if (g >= 0) begin
          m_mem[d][p_addr[d][g]] = nw;
          pend[d][g] = 1'b0;
          m_ptr[d]   = (g + 1) % 3;
        end
        if (npend > ((g >= 0) ? 1 : 0) && m_stall[d] < stall_max(d)) m_stall[d]++;
      end
      want[d]   = 3'b000;
      rd_req[d] = 1'b0;
    end
    prev_rst   = rst_req;
    regs_known = regs_known | rst_req;
    rst_req    = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && any_pend(); n++) step();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_valid[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_valid_unexpected dut0: got rd_valid=1 expected no read outstanding at %0t", $time);
      end else begin
        chk("rd_data", 0, rd_data[0], exp_q0.pop_front());
      end
    end
    if (rd_valid[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_valid_unexpected dut1: got rd_valid=1 expected no read outstanding at %0t", $time);
      end else begin
        chk("rd_data", 1, rd_data[1], exp_q1.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    regs_known = 1'b0;
    prev_rst = 1'b0;
    rst_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_valid[d] = '0; wr_addr[d] = '0; wr_data[d] = '0;
      rd_en[d] = 1'b0; rd_addr[d] = '0;
      want[d] = '0; rd_req[d] = 1'b0; rd_at[d] = '0;
      m_ptr[d] = 0; m_stall[d] = 0;
      for (int i = 0; i < 3; i++) begin
        pend[d][i] = 1'b0; p_addr[d][i] = '0; p_data[d][i] = '0;
        want_addr[d][i] = '0; want_data[d][i] = '0;
      end
      for (int a = 0; a < 16; a++) m_mem[d][a] = 32'h0;
    end

    rst_req = 1'b1; step();
    rst_req = 1'b1; step();

    // Channels 0 and 2 together cover every bit, so this defines every word.
    for (int a = 0; a < 16; a++) begin
      req_both(0, 4'(a), 16'h0000);
      req_both(2, 4'(a), 16'h0000);
      step();
      drain();
    end
    rst_req = 1'b1; step();

    // Each channel alone on word 3, then read it back: 0x5678CD34.
    req_both(0, 4'd3, 16'h1234); step();
    req_both(1, 4'd3, 16'hABCD); step();
    req_both(2, 4'd3, 16'h5678); step();
    rd_both(4'd3); step();
    step();

    // Three-way contention: two waiting cycles, grants in index order.
    req_both(0, 4'd8, 16'h1111);
    req_both(1, 4'd9, 16'h2222);
    req_both(2, 4'd10, 16'h3333);
    step(); step(); step();
    @(posedge clk); #1;
    chk("stall_after_contention", 0, {16'h0, stall_a}, 32'd2);
    chk("stall_after_contention", 1, {29'h0, stall_b}, 32'd2);

    // Channels 0 and 2 requesting back to back.
    for (int n = 0; n < 4; n++) begin
      req_both(0, 4'(n), 16'(16'hA000 + n));
      req_both(2, 4'(n + 4), 16'(16'hB000 + n));
      step();
    end
    drain();

    // Write and read of word 5 on the same edge.
    req_both(0, 4'd5, 16'hFFFF);
    rd_both(4'd5);
    step();
    step();

    // Reset while channels 1 and 2 wait with the round-robin pointer at 2.
    req_both(1, 4'd7, 16'h00AA);
    rd_both(4'd3);
    step();
    req_both(1, 4'd11, 16'h0C11);
    req_both(2, 4'd12, 16'h0C22);
    rst_req = 1'b1; step();
    rst_req = 1'b1; step();
    step(); step();
    drain();

    // Saturation: two channels always requesting.
    rst_req = 1'b1; step();
    for (int n = 0; n < 10; n++) begin
      req_both(0, 4'(n), 16'($urandom_range(0, 65535)));
      req_both(1, 4'(n + 3), 16'($urandom_range(0, 65535)));
      step();
    end
    @(posedge clk); #1;
    chk("stall_saturated", 1, {29'h0, stall_b}, 32'd7);
    chk("stall_unsaturated", 0, {16'h0, stall_a}, 32'd10);
    drain();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 1) == 1)
            req(d, i, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
        end
        if ($urandom_range(0, 2) == 0) begin
          rd_req[d] = 1'b1;
          rd_at[d]  = 4'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 99) == 0) rst_req = 1'b1;
      step();
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      rd_req[d] = 1'b1;
      rd_at[d]  = 4'd3;
    end
    step();
    step(); step();

    chk("reads_outstanding", 0, 32'(exp_q0.size()), 32'd0);
    chk("reads_outstanding", 1, 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
